eth_rx_packer: RTL

Upstream feeder for the Ethernet write port of Arbiter2. Takes an MII-style receive nibble stream, strips the preamble and SFD, and packs nibbles LSB-first into 32-bit words. It issues single-cycle write strobes (ewr_addr/ewr_write/ewr_data) into a fixed 128-word RAM window and holds a frame-ready handshake until the host acknowledges the frame.

---
 rtl/eth_rx_packer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/eth_rx_packer.sv
// eth_rx_packer: strips MII preamble/SFD and packs receive nibbles LSB-first into 32-bit RAM writes
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable_i                receiver enabled; frames starting while low are dropped
//   rx_dv_i, rx_d_i, rx_er_i  MII receive valid, nibble, error
//   ewr_addr_o/_write_o/_data_o  single-cycle write strobe into the receive window
//   frame_ready_o           frame stored, held until ack_i
//   frame_len_o             frame length in nibbles (excluding preamble/SFD)
//   frame_err_o, overflow_o frame status, valid while frame_ready_o
//   ack_i                   host releases the buffer
//   drop_cnt_o              saturating count of dropped frames
module eth_rx_packer #(
    parameter logic [8:0] BASE_ADDR = 9'h080,
    parameter int         WORDS     = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        rx_dv_i,
    input  logic [3:0]  rx_d_i,
    input  logic        rx_er_i,
    output logic [8:0]  ewr_addr_o,
    output logic        ewr_write_o,
    output logic [31:0] ewr_data_o,
    output logic        frame_ready_o,
    output logic [10:0] frame_len_o,
    output logic        frame_err_o,
    output logic        overflow_o,
    input  logic        ack_i,
    output logic [7:0]  drop_cnt_o
);
    localparam int IW = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {IDLE, PRE, DATA, OVF, DONE, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   sr_q, sr_d, sr_sh;
    logic [10:0]   cnt_q, cnt_d;
    logic [IW-1:0] widx_q, widx_d;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic          wr_q, wr_d;
    logic [8:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    drop_q, drop_d;
    logic          drop_inc;
    logic          rdy_q;
    // Previous rx_dv_i. Resets high so a frame already in flight when reset
    // releases is ignored until the line has gone idle once.
    logic          dv_q;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        drop_inc = 1'b0;
        sr_sh    = {rx_d_i, sr_q[31:4]};
        case (state_q)
            IDLE: if (rx_dv_i && !dv_q) begin
                state_d  = enable_i ? PRE : DROP;
                drop_inc = !enable_i;
            end
            PRE: if (!rx_dv_i) begin
                state_d = IDLE;
            end else if (rx_d_i == 4'hD) begin
                state_d = DATA;
                sr_d    = '0;
                cnt_d   = '0;
                widx_d  = '0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
            end else if (rx_d_i != 4'h5) begin
                state_d  = DROP;
                drop_inc = 1'b1;
            end
            DATA: if (!rx_dv_i) begin
                state_d = DONE;
                // Flush a partial word, right-aligned with zero upper nibbles.
                if (cnt_q[2:0] != 3'd0) begin
                    wr_d   = 1'b1;
                    addr_d = BASE_ADDR + 9'(widx_q);
                    data_d = sr_q >> (6'd32 - {1'b0, cnt_q[2:0], 2'b00});
                end
            end else if (widx_q == IW'(WORDS)) begin
                state_d = OVF;
                ovf_d   = 1'b1;
                err_d   = 1'b1;
            end else begin
                sr_d  = sr_sh;
                cnt_d = cnt_q + 11'd1;
                err_d = err_q | rx_er_i;
                if (cnt_q[2:0] == 3'd7) begin
                    wr_d   = 1'b1;
                    addr_d = BASE_ADDR + 9'(widx_q);
                    data_d = sr_sh;
                    widx_d = widx_q + IW'(1);
                end
            end
            OVF:  state_d = rx_dv_i ? OVF : DONE;
            DONE: begin
                drop_inc = rx_dv_i && !dv_q;
                if (ack_i) state_d = rx_dv_i ? DROP : IDLE;
            end
            DROP:    state_d = rx_dv_i ? DROP : IDLE;
            default: state_d = IDLE;
        endcase
        drop_d = drop_q + 8'(drop_inc && drop_q != 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= '0;
            rdy_q   <= 1'b0;
            dv_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            rdy_q   <= state_d == DONE;
            dv_q    <= rx_dv_i;
        end
    end

    assign ewr_addr_o    = addr_q;
    assign ewr_write_o   = wr_q;
    assign ewr_data_o    = data_q;
    assign frame_ready_o = rdy_q;
    assign frame_len_o   = cnt_q;
    assign frame_err_o   = err_q;
    assign overflow_o    = ovf_q;
    assign drop_cnt_o    = drop_q;
endmodule
